// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: ROM, redirect and decode-facing handshake bundle of the fetch stage.
interface instruction_fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rd;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   out_ready;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]    out_pc;
  logic                   halted;
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_rd, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_rd, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, combinational ROM addressing and valid/ready output register.
// IFETCH_HALT_ON_NULL_EN: stop fetching on an all-zero word until redirected.
module instruction_fetch #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t                 state, state_nx;
  logic [PC_WIDTH-1:0]    pc, pc_nx, out_pc, opc_nx;
  logic [INSTR_WIDTH-1:0] out_instr, instr_nx;
  logic                   out_valid, valid_nx, halted, halted_nx;
  logic                   fire, null_stop;
  assign fire = state == RUN && (!out_valid || bus.out_ready);
`ifdef IFETCH_HALT_ON_NULL_EN
  assign null_stop = bus.imem_rd == '0;
`else
  assign null_stop = 1'b0;
`endif
  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_instr;
  assign bus.out_pc    = out_pc;
  assign bus.halted    = halted;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      out_valid <= valid_nx;
      out_instr <= instr_nx;
      out_pc    <= opc_nx;
      halted    <= halted_nx;
    end
  end
  // Redirect outranks boot, fetch and stall; anything not listed simply holds.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    valid_nx  = out_valid;
    instr_nx  = out_instr;
    opc_nx    = out_pc;
    halted_nx = halted;
    if (bus.redirect_valid) begin
      pc_nx     = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
      valid_nx  = 1'b0;
      state_nx  = RUN;
      halted_nx = 1'b0;
    end else if (state == BOOT) begin
      state_nx = RUN;
    end else if (fire && null_stop) begin
      valid_nx  = 1'b0;
      state_nx  = HALT;
      halted_nx = 1'b1;
    end else if (fire) begin
      instr_nx = bus.imem_rd;
      opc_nx   = pc;
      valid_nx = 1'b1;
      pc_nx    = pc + PC_WIDTH'(4);
    end
  end
endmodule
